icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_pkg.sv | 45 ++++
 rtl/icache_beat_addr.sv | 18 +
 rtl/icache_refill.sv | 147 ++++++++++++++
 tb/tb_icache_refill.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: AHB encodings, refill FSM state codes and line geometry helpers
// shared by the I-cache refill engine and its beat address generator.
package icache_pkg;

  localparam int LINE_WORDS_DEFAULT = 4;
  localparam int INDEX_BITS_DEFAULT = 6;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_INCR  = 3'b001;
  localparam logic [2:0] HBURST_WRAP4 = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;
  localparam logic [2:0] HBURST_WRAP8 = 3'b100;
  localparam logic [2:0] HBURST_INCR8 = 3'b101;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_BURST = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int tag_bits(input int line_words, input int index_bits);
    return 32 - index_bits - offset_bits(line_words);
  endfunction

  // Two-word lines have no fixed-length AHB burst, so they fall back to INCR.
  function automatic logic [2:0] burst_code(input int line_words, input bit wrap);
    case (line_words)
      4:       return wrap ? HBURST_WRAP4 : HBURST_INCR4;
      8:       return wrap ? HBURST_WRAP8 : HBURST_INCR8;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/icache_beat_addr.sv
// icache_beat_addr: address of the current refill beat. The word offset wraps
// inside the line, so a zero start offset yields an INCR sequence.
module icache_beat_addr
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
  input  logic [31:$clog2(LINE_WORDS)+2]  line_base,
  input  logic [$clog2(LINE_WORDS)-1:0]   start_off,
  input  logic [$clog2(LINE_WORDS)-1:0]   beat_cnt,
  output logic [31:0]                     beat_addr,
  output logic [$clog2(LINE_WORDS)-1:0]   word_off
);

  assign word_off  = start_off + beat_cnt;
  assign beat_addr = {line_base, word_off, 2'b00};

endmodule

// File: rtl/icache_refill.sv
// icache_refill: fetches one cache line over AHB on a miss and presents it as
// a one-cycle fill. Define ICACHE_CRITICAL_WORD_FIRST_EN for WRAP bursts with critical-word forward.
module icache_refill
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        miss_valid,
  input  logic [31:0]                                 miss_addr,
  output logic                                        miss_ready,
  output logic [31:0]                                 haddr,
  output logic [1:0]                                  htrans,
  output logic [2:0]                                  hburst,
  output logic [2:0]                                  hsize,
  output logic                                        hwrite,
  input  logic                                        hready,
  input  logic [31:0]                                 hrdata,
  input  logic                                        hresp,
  output logic                                        fill_valid,
  output logic [INDEX_BITS-1:0]                       fill_index,
  output logic [tag_bits(LINE_WORDS, INDEX_BITS)-1:0] fill_tag,
  output logic [32*LINE_WORDS-1:0]                    fill_data,
  output logic                                        crit_valid,
  output logic [31:0]                                 crit_data,
  output logic                                        refill_err
);

  localparam int WB    = $clog2(LINE_WORDS);
  localparam int OFF_W = offset_bits(LINE_WORDS);
  localparam int TAG_W = tag_bits(LINE_WORDS, INDEX_BITS);
  localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [2:0] BURST_CODE = burst_code(LINE_WORDS, WRAP);

  state_t                       state;
  logic [31:2]                  addr_q;
  logic [WB-1:0]                beat_cnt;
  logic [WB-1:0]                start_off;
  logic [WB-1:0]                word_off;
  logic [WB-1:0]                dphase_off;
  logic                         dphase_valid;
  logic                         addr_phase;
  logic [31:0]                  beat_addr;
  logic [LINE_WORDS-1:0][31:0]  line_q;
  logic                         unused_byte_off;

  assign unused_byte_off = ^miss_addr[1:0];
  assign start_off  = WRAP ? addr_q[OFF_W-1:2] : '0;
  assign addr_phase = (state == ST_ADDR) || (state == ST_BURST);

  icache_beat_addr #(.LINE_WORDS(LINE_WORDS)) u_beat_addr (
    .line_base (addr_q[31:OFF_W]),
    .start_off (start_off),
    .beat_cnt  (beat_cnt),
    .beat_addr (beat_addr),
    .word_off  (word_off)
  );

  // dphase_* tracks the beat whose data phase is in flight one cycle behind its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      beat_cnt     <= '0;
      dphase_valid <= 1'b0;
      dphase_off   <= '0;
      line_q       <= '0;
    end else if (dphase_valid && hresp) begin
      state        <= ST_ERR;
      beat_cnt     <= '0;
      dphase_valid <= 1'b0;
      line_q       <= '0;
    end else begin
      if (hready) begin
        if (dphase_valid) line_q[dphase_off] <= hrdata;
        dphase_valid <= addr_phase;
        dphase_off   <= word_off;
      end
      case (state)
        ST_IDLE: if (miss_valid) begin
          addr_q <= miss_addr[31:2];
          state  <= ST_ADDR;
        end
        ST_ADDR: if (hready) begin
          beat_cnt <= beat_cnt + 1'b1;
          state    <= ST_BURST;
        end
        ST_BURST: if (hready) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            state    <= ST_DRAIN;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_DRAIN: if (hready) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic        crit_valid_q;
  logic [31:0] crit_data_q;

  // The first beat of a WRAP burst is the requested word; forward it as it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      if (dphase_valid && hready && !hresp && dphase_off == start_off) begin
        crit_valid_q <= 1'b1;
        crit_data_q  <= hrdata;
      end
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
`else
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

  assign miss_ready = (state == ST_IDLE);
  assign htrans     = (state == ST_ADDR)  ? HTRANS_NONSEQ :
                      (state == ST_BURST) ? HTRANS_SEQ    : HTRANS_IDLE;
  assign haddr      = addr_phase ? beat_addr : '0;
  assign hburst     = addr_phase ? BURST_CODE : 3'b000;
  assign hsize      = HSIZE_WORD;
  assign hwrite     = 1'b0;
  assign fill_valid = (state == ST_DONE);
  assign refill_err = (state == ST_ERR);
  assign fill_index = addr_q[OFF_W +: INDEX_BITS];
  assign fill_tag   = addr_q[31 -: TAG_W];
  assign fill_data  = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: scenario tasks against a line-level reference model and a
// small AHB slave that can insert wait states or an ERROR response.
module tb_icache_refill;

  localparam int LW   = 4;
  localparam int IB   = 6;
  localparam int OFFB = $clog2(LW * 4);
  localparam int TW   = 32 - IB - OFFB;
  localparam int LOGN = 64;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit         CWF       = 1'b1;
  localparam logic [2:0] EXP_BURST = 3'b010;
`else
  localparam bit         CWF       = 1'b0;
  localparam logic [2:0] EXP_BURST = 3'b011;
`endif

  logic              clk, rst, miss_valid, miss_ready;
  logic [31:0]       miss_addr, haddr, hrdata, crit_data;
  logic [1:0]        htrans;
  logic [2:0]        hburst, hsize;
  logic              hwrite, hready, hresp, fill_valid, crit_valid, refill_err;
  logic [IB-1:0]     fill_index;
  logic [TW-1:0]     fill_tag;
  logic [32*LW-1:0]  fill_data;

  icache_refill #(.LINE_WORDS(LW), .INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
    .hready(hready), .hrdata(hrdata), .hresp(hresp),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
    .crit_valid(crit_valid), .crit_data(crit_data), .refill_err(refill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc;
  logic [31:0] seed;
  bit          hold_miss;

  bit          dp_pending;
  logic [31:0] dp_addr;
  int          dp_beat, beat_ctr, wait_beat, waits_left, err_beat;

  logic [1:0]  lg_trans[LOGN];
  logic [31:0] lg_addr[LOGN];
  logic [2:0]  lg_burst[LOGN];
  logic        lg_hready[LOGN], lg_fill[LOGN], lg_err[LOGN], lg_ready[LOGN], lg_crit[LOGN];
  logic [32*LW-1:0] fill_cap;
  logic [IB-1:0]    index_cap;
  logic [TW-1:0]    tag_cap;
  logic [31:0]      crit_cap;
  bit               crit_nonzero;

  int          acc_n, busy_n, nonseq_n, nonseq2_cyc, fill_n, fill_cyc, err_n, err_cyc, crit_n, idle_bad;
  logic [31:0] acc_addr[LOGN];
  logic [1:0]  acc_trans[LOGN];
  logic [2:0]  burst_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
    int w;
    w = int'((a >> 2) % LW);
    if (CWF) return line_base(a) + 32'(((w + i) % LW) * 4);
    return line_base(a) + 32'(i * 4);
  endfunction

  function automatic logic [32*LW-1:0] exp_line(input logic [31:0] a);
    logic [32*LW-1:0] r;
    for (int j = 0; j < LW; j++) r[j*32 +: 32] = mem_word(line_base(a) + 32'(4 * j));
    return r;
  endfunction

  // Log the DUT outputs of the current cycle, then answer as an AHB slave.
  task automatic sample_and_drive();
    if (cyc < LOGN) begin
      lg_trans[cyc] = htrans;  lg_addr[cyc] = haddr;  lg_burst[cyc] = hburst;
      lg_fill[cyc]  = fill_valid; lg_err[cyc] = refill_err;
      lg_ready[cyc] = miss_ready; lg_crit[cyc] = crit_valid;
    end
    if (fill_valid) begin fill_cap = fill_data; index_cap = fill_index; tag_cap = fill_tag; end
    if (crit_valid) crit_cap = crit_data;
    if (crit_data !== 32'd0) crit_nonzero = 1'b1;
    hresp = 1'b0; hready = 1'b1; hrdata = $urandom;
    if (dp_pending) begin
      hrdata = mem_word(dp_addr);
      if (dp_beat == err_beat) hresp = 1'b1;
      else if (dp_beat == wait_beat && waits_left > 0) begin
        hready = 1'b0; hrdata = $urandom; waits_left--;
      end
    end
    if (cyc < LOGN) lg_hready[cyc] = hready;
    if (hready) begin
      if (htrans == 2'b10) beat_ctr = 0;
      if (htrans[1]) begin
        dp_pending = 1'b1; dp_addr = haddr; dp_beat = beat_ctr; beat_ctr++;
      end else dp_pending = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
    cyc++;
    if (!hold_miss) miss_valid = 1'b0;
    sample_and_drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_miss(input logic [31:0] a);
    @(posedge clk); @(negedge clk);
    cyc = 0;
    for (int i = 0; i < LOGN; i++) begin
      lg_trans[i] = '0; lg_addr[i] = '0; lg_burst[i] = '0; lg_hready[i] = 1'b0;
      lg_fill[i] = 1'b0; lg_err[i] = 1'b0; lg_ready[i] = 1'b0; lg_crit[i] = 1'b0;
    end
    fill_cap = '0; index_cap = '0; tag_cap = '0; crit_cap = '0; crit_nonzero = 1'b0;
    miss_valid = 1'b1; miss_addr = a;
    sample_and_drive();
  endtask

  // Reduces the cycle log of one scenario to counts and the accepted address list.
  task automatic collect(input int last);
    acc_n = 0; busy_n = 0; nonseq_n = 0; nonseq2_cyc = -1; fill_n = 0; fill_cyc = -1;
    err_n = 0; err_cyc = -1; crit_n = 0; idle_bad = 0; burst_seen = 'x;
    for (int c = 0; c <= last && c < LOGN; c++) begin
      if (lg_trans[c] != 2'b00) begin
        busy_n++;
        if (lg_trans[c] == 2'b10) begin
          nonseq_n++;
          if (nonseq_n == 1) burst_seen = lg_burst[c];
          if (nonseq_n == 2) nonseq2_cyc = c;
        end
        if (lg_hready[c]) begin acc_addr[acc_n] = lg_addr[c]; acc_trans[acc_n] = lg_trans[c]; acc_n++; end
      end
      if (lg_fill[c]) begin fill_n++; if (fill_cyc < 0) fill_cyc = c; end
      if (lg_err[c])  begin err_n++;  if (err_cyc < 0)  err_cyc = c;  end
      if (lg_crit[c]) crit_n++;
      if ((lg_fill[c] || lg_err[c] || lg_ready[c]) && (lg_addr[c] != 32'd0 || lg_trans[c] != 2'b00)) idle_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    hold_miss = 1'b0; dp_pending = 1'b0; beat_ctr = 0; dp_beat = 0;
    wait_beat = -1; waits_left = 0; err_beat = -1; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (htrans !== 2'b00)   begin failures++; $display("[TB] FAIL reset_htrans got=%0h want=0", htrans); end
    checks++; if (haddr !== 32'd0)    begin failures++; $display("[TB] FAIL reset_haddr got=%08h want=0", haddr); end
    checks++; if (hburst !== 3'b000)  begin failures++; $display("[TB] FAIL reset_hburst got=%0h want=0", hburst); end
    checks++; if (hsize !== 3'b010)   begin failures++; $display("[TB] FAIL reset_hsize got=%0h want=2", hsize); end
    checks++; if (hwrite !== 1'b0)    begin failures++; $display("[TB] FAIL reset_hwrite got=%0b want=0", hwrite); end
    checks++; if (fill_valid !== 1'b0 || refill_err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pulses fill=%0b err=%0b want=0 0", fill_valid, refill_err); end
    checks++; if (crit_valid !== 1'b0 || crit_data !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_crit valid=%0b data=%08h want=0 0", crit_valid, crit_data); end
    checks++; if (fill_data !== '0)   begin failures++; $display("[TB] FAIL reset_fill_data got=%h want=0", fill_data); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (miss_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_miss_ready got=%0b want=1", miss_ready); end
  endtask

  task automatic test_zero_wait_miss();
    logic [31:0] a = 32'h0000_1008;
    start_miss(a); run(LW + 6); collect(cyc);
    checks++; if (acc_n != LW) begin failures++; $display("[TB] FAIL zw_beats got=%0d want=%0d", acc_n, LW); end
    for (int i = 0; i < LW && i < acc_n; i++) begin
      checks++;
      if (acc_addr[i] !== exp_addr(a, i) || acc_trans[i] !== (i == 0 ? 2'b10 : 2'b11)) begin
        failures++;
        $display("[TB] FAIL zw_beat%0d got=%08h/%0h want=%08h/%0h", i, acc_addr[i], acc_trans[i], exp_addr(a, i), (i == 0 ? 2'b10 : 2'b11));
      end
    end
    checks++; if (burst_seen !== EXP_BURST) begin failures++; $display("[TB] FAIL zw_hburst got=%0h want=%0h", burst_seen, EXP_BURST); end
    checks++; if (fill_n != 1 || fill_cyc != 2 + LW) begin
      failures++; $display("[TB] FAIL zw_fill_timing got=%0d@%0d want=1@%0d", fill_n, fill_cyc, 2 + LW); end
    checks++; if (fill_cap !== exp_line(a)) begin failures++; $display("[TB] FAIL zw_fill_data got=%h want=%h", fill_cap, exp_line(a)); end
    checks++; if (index_cap !== IB'(a >> OFFB) || tag_cap !== TW'(a >> (OFFB + IB))) begin
      failures++; $display("[TB] FAIL zw_index_tag got=%0h/%0h want=%0h/%0h", index_cap, tag_cap, IB'(a >> OFFB), TW'(a >> (OFFB + IB))); end
    checks++; if (err_n != 0 || idle_bad != 0) begin
      failures++; $display("[TB] FAIL zw_err_idle got=%0d/%0d want=0/0", err_n, idle_bad); end
    checks++;
    if (CWF) begin
      if (crit_n != 1 || crit_cap !== mem_word(a)) begin
        failures++; $display("[TB] FAIL zw_crit got=%0d/%08h want=1/%08h", crit_n, crit_cap, mem_word(a)); end
    end else if (crit_n != 0 || crit_nonzero) begin
      failures++; $display("[TB] FAIL zw_crit_tied got=%0d/%0b want=0/0", crit_n, crit_nonzero);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a = 32'h0000_1008;
    int held_bad = 0;
    wait_beat = 2; waits_left = 2;
    start_miss(a); run(LW + 8); collect(cyc);
    for (int c = 0; c <= cyc; c++)
      if (!lg_hready[c] && (lg_addr[c] !== exp_addr(a, 3) || lg_trans[c] !== 2'b11)) held_bad++;
    checks++; if (held_bad != 0) begin failures++; $display("[TB] FAIL ws_hold got=%0d_bad_cycles want=0", held_bad); end
    checks++; if (busy_n != LW + 2) begin failures++; $display("[TB] FAIL ws_busy got=%0d want=%0d", busy_n, LW + 2); end
    checks++; if (fill_n != 1 || fill_cyc != 4 + LW) begin
      failures++; $display("[TB] FAIL ws_fill_timing got=%0d@%0d want=1@%0d", fill_n, fill_cyc, 4 + LW); end
    checks++; if (fill_cap !== exp_line(a)) begin failures++; $display("[TB] FAIL ws_fill_data got=%h want=%h", fill_cap, exp_line(a)); end
    wait_beat = -1;
  endtask

  task automatic test_error();
    logic [31:0] a = 32'h0000_2A34;
    int late_busy = 0;
    err_beat = 1;
    start_miss(a); run(LW + 6); collect(cyc);
    for (int c = 4; c <= cyc; c++) if (lg_trans[c] != 2'b00) late_busy++;
    checks++; if (err_n != 1 || err_cyc != 4) begin failures++; $display("[TB] FAIL err_pulse got=%0d@%0d want=1@4", err_n, err_cyc); end
    checks++; if (late_busy != 0) begin failures++; $display("[TB] FAIL err_htrans_idle got=%0d want=0", late_busy); end
    checks++; if (fill_n != 0) begin failures++; $display("[TB] FAIL err_no_fill got=%0d want=0", fill_n); end
    checks++; if (lg_ready[5] !== 1'b1) begin failures++; $display("[TB] FAIL err_ready got=%0b want=1", lg_ready[5]); end
    err_beat = -1;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a = 32'h0040_0C14;
    logic [31:0] b = 32'h0000_3FF0;
    start_miss(a); run(3);
    rst = 1'b1; tick();
    checks++; if (htrans !== 2'b00 || haddr !== 32'd0) begin
      failures++; $display("[TB] FAIL rmb_abandon got=%0h/%08h want=0/0", htrans, haddr); end
    rst = 1'b0; run(LW + 4); collect(cyc);
    checks++; if (fill_n != 0 || err_n != 0) begin failures++; $display("[TB] FAIL rmb_quiet got=%0d/%0d want=0/0", fill_n, err_n); end
    start_miss(b); run(LW + 6); collect(cyc);
    checks++; if (fill_n != 1 || fill_cyc != 2 + LW || fill_cap !== exp_line(b)) begin
      failures++; $display("[TB] FAIL rmb_next_miss got=%0d@%0d %h want=1@%0d %h", fill_n, fill_cyc, fill_cap, 2 + LW, exp_line(b)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a = 32'h0000_5504;
    hold_miss = 1'b1;
    start_miss(a); run(2 * (LW + 3) - 1); collect(cyc);
    checks++; if (nonseq_n != 2 || nonseq2_cyc != LW + 4) begin
      failures++; $display("[TB] FAIL b2b_bursts got=%0d@%0d want=2@%0d", nonseq_n, nonseq2_cyc, LW + 4); end
    checks++; if (fill_n != 2 || busy_n != 2 * LW) begin
      failures++; $display("[TB] FAIL b2b_fills got=%0d/%0d want=2/%0d", fill_n, busy_n, 2 * LW); end
    hold_miss = 1'b0; miss_valid = 1'b0;
    run(LW + 8);
  endtask

  task automatic test_random_misses();
    for (int n = 0; n < 12; n++) begin
      logic [31:0] a;
      int nw, seq_bad;
      a = $urandom; nw = $urandom_range(0, 3);
      wait_beat = $urandom_range(0, LW - 1); waits_left = nw;
      start_miss(a); run(LW + nw + 6); collect(cyc);
      seq_bad = (acc_n != LW) ? 1 : 0;
      for (int i = 0; i < LW && i < acc_n; i++) if (acc_addr[i] !== exp_addr(a, i)) seq_bad++;
      checks++; if (seq_bad != 0) begin failures++; $display("[TB] FAIL rnd%0d_addr_seq a=%08h got=%0d_bad want=0", n, a, seq_bad); end
      checks++; if (fill_n != 1 || fill_cyc != 2 + LW + nw) begin
        failures++; $display("[TB] FAIL rnd%0d_fill_timing got=%0d@%0d want=1@%0d", n, fill_n, fill_cyc, 2 + LW + nw); end
      checks++; if (fill_cap !== exp_line(a) || index_cap !== IB'(a >> OFFB) || tag_cap !== TW'(a >> (OFFB + IB))) begin
        failures++; $display("[TB] FAIL rnd%0d_fill a=%08h got=%h want=%h", n, a, fill_cap, exp_line(a)); end
      if (CWF) begin
        checks++; if (crit_n != 1 || crit_cap !== mem_word(a)) begin
          failures++; $display("[TB] FAIL rnd%0d_crit got=%0d/%08h want=1/%08h", n, crit_n, crit_cap, mem_word(a)); end
      end
    end
    wait_beat = -1; waits_left = 0;
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_zero_wait_miss();
    test_wait_states();
    test_error();
    test_reset_mid_burst();
    test_back_to_back();
    test_random_misses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
